// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer sitting in front of the CSR file.
//
// Takes ecall / ebreak / illegal-instruction / mret requests from execute,
// writes mcause, mepc and mstatus through three dedicated CSR write ports,
// then holds a PC redirect towards fetch until it is accepted. Younger
// instructions are flushed for as long as a trap is in flight.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   trap_valid/trap_ready    request handshake from execute
//   trap_type                00 ecall, 01 ebreak, 10 illegal, 11 mret
//   trap_pc                  PC of the trapping instruction
//   mstatus_in/mtvec_in/mepc_in  current CSR values
//   csr_wen1/addr1/wdata1    mcause write port (0x342)
//   csr_wen2/addr2/wdata2    mepc write port    (0x341)
//   csr_wen3/addr3/wdata3    mstatus write port (0x300)
//   flush                    kill younger in-flight instructions
//   redirect_valid/ready/pc  new-PC request to fetch
//   trap_cnt                 completed trap entries (mret not counted)
module trap_ctrl #(
    parameter logic [31:0] ECALL_CAUSE   = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE  = 32'd3,
    parameter logic [31:0] ILLEGAL_CAUSE = 32'd2,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_valid,
    output logic             trap_ready,
    input  logic [1:0]       trap_type,
    input  logic [31:0]      trap_pc,
    input  logic [31:0]      mstatus_in,
    input  logic [31:0]      mtvec_in,
    input  logic [31:0]      mepc_in,
    output logic             csr_wen1,
    output logic [11:0]      csr_addr1,
    output logic [31:0]      csr_wdata1,
    output logic             csr_wen2,
    output logic [11:0]      csr_addr2,
    output logic [31:0]      csr_wdata2,
    output logic             csr_wen3,
    output logic [11:0]      csr_addr3,
    output logic [31:0]      csr_wdata3,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ENTER    = 2'b01,
        RETURN   = 2'b10,
        REDIRECT = 2'b11
    } state_t;

    // Word-aligns a PC; low two bits are forced to zero.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t state_r;

    // mcause value for a trap-entry type.
    function automatic logic [31:0] cause_of(input logic [1:0] t);
        logic [31:0] c;
        case (t)
            2'b00:   c = ECALL_CAUSE;
            2'b01:   c = EBREAK_CAUSE;
            2'b10:   c = ILLEGAL_CAUSE;
            default: c = 32'd0;
        endcase
        return c;
    endfunction

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [31:0] enter_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r         = m;
        r[7]      = m[3];
        r[3]      = 1'b0;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP stays M (M-mode only).
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r         = m;
        r[3]      = m[7];
        r[7]      = 1'b1;
        r[12:11]  = 2'b11;
        return r;
    endfunction

    assign csr_addr1  = 12'h342;
    assign csr_addr2  = 12'h341;
    assign csr_addr3  = 12'h300;
    assign trap_ready = (state_r == IDLE);

    // Sequencer: state plus every registered output. The write enables are
    // loaded on the accepting edge so they are high for exactly the one
    // ENTER/RETURN cycle and are cleared by default on every other edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            csr_wen1       <= 1'b0;
            csr_wen2       <= 1'b0;
            csr_wen3       <= 1'b0;
            csr_wdata1     <= 32'd0;
            csr_wdata2     <= 32'd0;
            csr_wdata3     <= 32'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            trap_cnt       <= {CNT_W{1'b0}};
        end else begin
            csr_wen1 <= 1'b0;
            csr_wen2 <= 1'b0;
            csr_wen3 <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trap_valid) begin
                        flush <= 1'b1;
                        if (trap_type == 2'b11) begin
                            state_r    <= RETURN;
                            csr_wen3   <= 1'b1;
                            csr_wdata3 <= mret_mstatus(mstatus_in);
                        end else begin
                            state_r    <= ENTER;
                            csr_wen1   <= 1'b1;
                            csr_wen2   <= 1'b1;
                            csr_wen3   <= 1'b1;
                            csr_wdata1 <= cause_of(trap_type);
                            csr_wdata2 <= trap_pc & ALIGN_MASK;
                            csr_wdata3 <= enter_mstatus(mstatus_in);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ENTER: begin
                    redirect_pc    <= mtvec_in & ALIGN_MASK;
                    redirect_valid <= 1'b1;
                    trap_cnt       <= trap_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_r        <= REDIRECT;
                end
                RETURN: begin
                    redirect_pc    <= mepc_in & ALIGN_MASK;
                    redirect_valid <= 1'b1;
                    state_r        <= REDIRECT;
                end
                REDIRECT: begin
                    // redirect_pc is left untouched here so it stays stable
                    // for the whole time fetch is back-pressuring.
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                        state_r        <= IDLE;
                    end else begin
                        state_r <= REDIRECT;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule
